bp_fe_fetch_queue: RTL
======================

Name: bp_fe_fetch_queue

Overview:
- Decoupling FIFO directly downstream of the PC generation stage.
- Accepts fetch packets (PC, instruction, branch metadata) and produces the fetch-side yumi that retires a packet from PC generation.
- Presents packets in order to the backend's fetch consumer.
- A backend redirect flushes all queued packets, so wrong-path instructions never reach the backend.

Parameters:
- vaddr_width_p, 39, virtual address width of the fetch PC.
- instr_width_p, 32, instruction width.
- branch_metadata_fwd_width_p, 36, width of the opaque branch metadata carried with each packet.
- els_p, 8, queue depth. Must be a power of two and at least 2. Pointer width is $clog2(els_p).

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- reset_n_i  in  1  asynchronous active-low reset.
- flush_i  in  1  redirect flush; discards all entries.
- fetch_v_i  in  1  a fetch packet is offered.
- fetch_pc_i  in  vaddr_width_p  PC of the offered packet.
- fetch_instr_i  in  instr_width_p  instruction of the offered packet.
- fetch_br_metadata_i  in  branch_metadata_fwd_width_p  branch metadata of the offered packet.
- fetch_yumi_o  out  1  packet accepted this cycle.
- fe_queue_v_o  out  1  head entry valid.
- fe_queue_pc_o  out  vaddr_width_p  head PC.
- fe_queue_instr_o  out  instr_width_p  head instruction.
- fe_queue_br_metadata_o  out  branch_metadata_fwd_width_p  head branch metadata.
- fe_queue_yumi_i  in  1  consumer takes the head entry.
- count_o  out  $clog2(els_p+1)  current occupancy.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. Asserting reset_n_i low immediately clears rptr, wptr, the wrap bits and count, at any point mid-operation. Storage RAM is not reset.
- Reset values: fe_queue_v_o=0, count_o=0, fetch_yumi_o=0 (because fetch_v_i is gated by reset).
- Pointers: rptr and wptr, each with an extra wrap bit.
  - empty = (rptr == wptr).
  - full = (index bits equal) & (wrap bits differ).
  - Index increment wraps from els_p-1 to 0 and toggles the wrap bit.
- Enqueue handshake: fetch_yumi_o = fetch_v_i & ~full & ~flush_i & reset_n_i.
  - fetch_yumi_o is combinational from registered state plus fetch_v_i and flush_i only. It must not depend on fe_queue_yumi_i, so there is no full-queue pass-through.
  - On yumi, the packet is written at wptr and wptr advances.
- Dequeue: fe_queue_v_o = ~empty. The head fields read storage at rptr.
  - fe_queue_yumi_i while fe_queue_v_o=1 advances rptr.
  - fe_queue_yumi_i while empty is illegal. The bench flags it. RAM behaviour is don't-care, and pointers must not move.
- Latency: a packet enqueued in cycle N is visible at the head in cycle N+1 at the earliest. There is no same-cycle bypass.
- Simultaneous enqueue and dequeue:
  - Not full, not empty: both pointers advance and count is unchanged.
  - Full: only the dequeue happens, because yumi_o=0.
  - Empty: only the enqueue happens.
- Flush: flush_i=1 sets rptr<=wptr and count<=0 at the next edge.
  - The same-cycle enqueue is suppressed (yumi_o=0).
  - The same-cycle fe_queue_yumi_i is ignored.
  - fe_queue_v_o=0 in the following cycle.
- Count: count_o is a registered value that tracks enqueues minus dequeues. Range 0..els_p, and it never wraps.
- Head data when empty: don't-care. The bench must not check it.

Test Plan:
- Reset then fill: reset_n_i low 3 cycles, release, drive 8 packets with PC 0x80000000+4k back-to-back → fetch_yumi_o high 8 cycles then 0, count_o=8, fe_queue_v_o=1, head PC 0x80000000.
- Drain order: from the full state, hold fe_queue_yumi_i=1 for 8 cycles → head PCs 0x80000000..0x8000001C in order, then fe_queue_v_o=0 and count_o=0.
- Wrap-around under streaming: enqueue and dequeue every cycle for 20 packets starting at count 3 → count_o stays 3, output PCs are strictly sequential, and no entry is lost across the pointer wrap.
- Full with simultaneous dequeue: full queue, fetch_v_i=1 and fe_queue_yumi_i=1 → fetch_yumi_o=0 that cycle, count_o=7 next cycle, fetch_yumi_o=1 the cycle after.
- Flush collision: count 5, assert flush_i together with fetch_v_i and fe_queue_yumi_i → fetch_yumi_o=0, next cycle count_o=0 and fe_queue_v_o=0; a packet enqueued after that appears at head 1 cycle later.
- Async reset mid-operation: count 4, drop reset_n_i between clock edges → fe_queue_v_o and count_o go to 0 before the next edge; after release, the first new packet is the head.

Source files
------------

// File: rtl/bp_fe_fetch_queue.sv
// bp_fe_fetch_queue: in-order fetch packet FIFO with redirect flush between PC generation and backend
module bp_fe_fetch_queue #(
   parameter int vaddr_width_p               = 39,
   parameter int instr_width_p               = 32,
   parameter int branch_metadata_fwd_width_p = 36,
   parameter int els_p                       = 8
) (
   input  logic                                   clk_i,
   input  logic                                   reset_n_i,
   input  logic                                   flush_i,
   input  logic                                   fetch_v_i,
   input  logic [vaddr_width_p-1:0]               fetch_pc_i,
   input  logic [instr_width_p-1:0]               fetch_instr_i,
   input  logic [branch_metadata_fwd_width_p-1:0] fetch_br_metadata_i,
   output logic                                   fetch_yumi_o,
   output logic                                   fe_queue_v_o,
   output logic [vaddr_width_p-1:0]               fe_queue_pc_o,
   output logic [instr_width_p-1:0]               fe_queue_instr_o,
   output logic [branch_metadata_fwd_width_p-1:0] fe_queue_br_metadata_o,
   input  logic                                   fe_queue_yumi_i,
   output logic [$clog2(els_p+1)-1:0]             count_o
);
   localparam int ptr_w = $clog2(els_p);
   localparam int cnt_w = $clog2(els_p+1);
   localparam int pkt_w = vaddr_width_p + instr_width_p + branch_metadata_fwd_width_p;
   logic [pkt_w-1:0] mem_q [els_p];
   logic [ptr_w:0]   rptr_q, rptr_d, wptr_q, wptr_d;
   logic [cnt_w-1:0] count_q, count_d;
   logic             empty, full, enq, deq;
   // Pointers carry an extra wrap bit so full and empty are distinguishable at equal indices
   always_comb begin
      empty   = rptr_q == wptr_q;
      full    = (rptr_q[ptr_w-1:0] == wptr_q[ptr_w-1:0]) & (rptr_q[ptr_w] != wptr_q[ptr_w]);
      enq     = fetch_v_i & ~full & ~flush_i & reset_n_i;
      deq     = fe_queue_yumi_i & ~empty & ~flush_i;
      wptr_d  = enq ? wptr_q + (ptr_w+1)'(1) : wptr_q;
      rptr_d  = flush_i ? wptr_q : deq ? rptr_q + (ptr_w+1)'(1) : rptr_q;
      count_d = flush_i ? '0 : count_q + cnt_w'(enq) - cnt_w'(deq);
   end
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk_i) begin
      if (enq) mem_q[wptr_q[ptr_w-1:0]] <= {fetch_pc_i, fetch_instr_i, fetch_br_metadata_i};
   end
   assign fetch_yumi_o = enq;
   assign fe_queue_v_o = ~empty;
   assign count_o      = count_q;
   assign {fe_queue_pc_o, fe_queue_instr_o, fe_queue_br_metadata_o} = mem_q[rptr_q[ptr_w-1:0]];
endmodule
